// File: rtl/eth_frame_checker.sv
// Receive-side test frame checker for one 10G MAC channel: validates length, incrementing byte
// pattern and inter-frame seed sequence, and keeps saturating good/bad counters plus a link lock flag.
module eth_frame_checker #(
  parameter logic [7:0]  P_MIN_LENGTH  = 8'd64,
  parameter logic [14:0] P_MAX_LENGTH  = 15'd9600,
  parameter logic [7:0]  P_LOCK_FRAMES = 8'd16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_rx_axis_data,
  input  logic [7:0]  i_rx_axis_keep,
  input  logic        i_rx_axis_last,
  input  logic        i_rx_axis_user,
  input  logic        i_rx_axis_valid,
  output logic        o_rx_axis_ready,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [15:0] o_frame_len,
  output logic [4:0]  o_err_flags,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt,
  output logic        o_link_ok
);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DONE} state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [7:0]  seed;
  logic [7:0]  prev_seed;
  logic        seq_valid;
  logic        pat_err;
  logic [7:0]  run_cnt;

  logic        accept;
  logic        first_beat;
  logic [7:0]  cur_seed;
  logic [15:0] base_cnt;
  logic [3:0]  keep_bytes;
  logic [16:0] len_sum;
  logic [15:0] len_next;
  logic        lane_err;
  logic        keep_gap;
  logic        pat_next;
  logic        too_short;
  logic        too_long;
  logic        seq_err;
  logic [4:0]  flags_next;
  logic        frame_good;
  logic [7:0]  run_next;

  // A beat taken outside RECV starts a new frame, so DONE behaves like IDLE for back-to-back frames.
  always_comb begin
    accept     = i_rx_axis_valid & o_rx_axis_ready;
    first_beat = (state != ST_RECV);
    cur_seed   = first_beat ? i_rx_axis_data[7:0] : seed;
    base_cnt   = first_beat ? '0 : byte_cnt;
    keep_bytes = '0;
    lane_err   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      keep_bytes = keep_bytes + {3'b000, i_rx_axis_keep[i]};
      if (i_rx_axis_keep[i] &&
          (i_rx_axis_data[8*i +: 8] != 8'(cur_seed + base_cnt[7:0] + 8'(i))))
        lane_err = 1'b1;
    end
    len_sum    = {1'b0, base_cnt} + 17'(keep_bytes);
    len_next   = len_sum[16] ? '1 : len_sum[15:0];
    // Contiguous-from-bit-0 masks are exactly those with no bit set above a zero bit.
    keep_gap   = (i_rx_axis_keep & (i_rx_axis_keep + 8'd1)) != '0;
    pat_next   = (~first_beat & pat_err) | lane_err | (i_rx_axis_last & keep_gap);
    too_short  = len_next < 16'(P_MIN_LENGTH);
    too_long   = len_next > 16'(P_MAX_LENGTH);
    seq_err    = seq_valid & (cur_seed != 8'(prev_seed + 8'd1));
    flags_next = {seq_err, i_rx_axis_user, pat_next, too_long, too_short};
    frame_good = (flags_next == '0);
    if (!frame_good)
      run_next = '0;
    else if (run_cnt >= P_LOCK_FRAMES)
      run_next = P_LOCK_FRAMES;
    else
      run_next = run_cnt + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      byte_cnt        <= '0;
      seed            <= '0;
      prev_seed       <= '0;
      seq_valid       <= 1'b0;
      pat_err         <= 1'b0;
      run_cnt         <= '0;
      o_rx_axis_ready <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_ok      <= 1'b0;
      o_frame_len     <= '0;
      o_err_flags     <= '0;
      o_good_cnt      <= '0;
      o_bad_cnt       <= '0;
      o_link_ok       <= 1'b0;
    end else begin
      o_rx_axis_ready <= 1'b1;
      o_frame_done    <= 1'b0;
      if (accept) begin
        if (i_rx_axis_last) begin
          state        <= ST_DONE;
          o_frame_done <= 1'b1;
          o_frame_ok   <= frame_good;
          o_frame_len  <= len_next;
          o_err_flags  <= flags_next;
          prev_seed    <= cur_seed;
          seq_valid    <= ~(i_rx_axis_user | too_long);
          byte_cnt     <= '0;
          pat_err      <= 1'b0;
          run_cnt      <= run_next;
          o_link_ok    <= (run_next == P_LOCK_FRAMES);
          if (frame_good) begin
            if (o_good_cnt != '1)
              o_good_cnt <= o_good_cnt + 32'd1;
          end else begin
            if (o_bad_cnt != '1)
              o_bad_cnt <= o_bad_cnt + 32'd1;
          end
        end else begin
          state    <= ST_RECV;
          byte_cnt <= len_next;
          pat_err  <= pat_next;
          seed     <= cur_seed;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_checker.sv
// Scoreboard bench for eth_frame_checker: frame-level reference model pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_eth_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        last;
  logic        user;
  logic        valid;
  logic        ready;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_len;
  logic [4:0]  err_flags;
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
  logic        link_ok;

  eth_frame_checker #(
    .P_MIN_LENGTH (8'd64),
    .P_MAX_LENGTH (15'd9600),
    .P_LOCK_FRAMES(8'd16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_axis_data (data),
    .i_rx_axis_keep (keep),
    .i_rx_axis_last (last),
    .i_rx_axis_user (user),
    .i_rx_axis_valid(valid),
    .o_rx_axis_ready(ready),
    .o_frame_done   (frame_done),
    .o_frame_ok     (frame_ok),
    .o_frame_len    (frame_len),
    .o_err_flags    (err_flags),
    .o_good_cnt     (good_cnt),
    .o_bad_cnt      (bad_cnt),
    .o_link_ok      (link_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [4:0]  flags;
    logic [31:0] good;
    logic [31:0] bad;
    logic        link;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // reference model state
  bit         m_seq_valid = 1'b0;
  logic [7:0] m_prev = '0;
  int         m_good = 0;
  int         m_bad = 0;
  int         m_run = 0;
  logic [7:0] next_seed = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", frame_done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_latency", cyc, e.cyc);
        check("frame_len", frame_len, e.len);
        check("err_flags", err_flags, e.flags);
        check("frame_ok", frame_ok, e.flags == 5'd0);
        check("good_cnt", good_cnt, e.good);
        check("bad_cnt", bad_cnt, e.bad);
        check("link_ok", link_ok, e.link);
      end
    end
  end

  function automatic bit is_contig(input logic [7:0] k);
    for (int n = 0; n <= 8; n++)
      if (k == 8'((1 << n) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
    end
  endtask

  // Sends one frame of len pattern bytes; keep_ovr (if nonzero) replaces the last-beat keep.
  task automatic send_frame(input int len, input logic [7:0] seed, input int bad_idx,
                            input bit usr, input logic [7:0] keep_ovr, input bit gaps);
    logic [7:0] d[];
    int         nbeats;
    logic [7:0] last_keep;
    int         meas;
    bit         pat, short_e, long_e, seq_e;
    exp_t       e;
    d = new[len];
    for (int i = 0; i < len; i++) d[i] = 8'(seed + i);
    if (bad_idx > 0 && bad_idx < len) d[bad_idx] = d[bad_idx] ^ 8'h5A;
    nbeats = (len + 7) / 8;
    if (keep_ovr != 8'h00)     last_keep = keep_ovr;
    else if (len % 8 == 0)     last_keep = 8'hFF;
    else                       last_keep = 8'((1 << (len % 8)) - 1);

    meas = (nbeats - 1) * 8 + $countones(last_keep);
    pat = !is_contig(last_keep);
    for (int i = 1; i < len; i++) if (d[i] != 8'(d[0] + i)) pat = 1'b1;
    short_e = meas < 64;
    long_e  = meas > 9600;
    seq_e   = m_seq_valid && (d[0] != 8'(m_prev + 1));
    e.len   = 16'(meas);
    e.flags = {seq_e, usr, pat, long_e, short_e};
    m_prev      = d[0];
    m_seq_valid = !(usr || long_e);
    if (e.flags == 5'd0) begin
      m_good++;
      if (m_run < 16) m_run++;
    end else begin
      m_bad++;
      m_run = 0;
    end
    e.good = 32'(m_good);
    e.bad  = 32'(m_bad);
    e.link = (m_run == 16);

    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(3) == 0) idle(1 + $urandom_range(2));
      @(negedge clk);
      valid = 1'b1;
      last  = (b == nbeats - 1);
      keep  = last ? last_keep : 8'hFF;
      user  = last ? usr : 1'($urandom);
      for (int l = 0; l < 8; l++) begin
        int idx = b * 8 + l;
        data[8*l +: 8] = (idx < len) ? d[idx] : 8'($urandom);
      end
      if (last) begin
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end
    next_seed = 8'(seed + 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_ok"}, frame_ok, 1'b0);
    check({tag, "_len"}, frame_len, 16'd0);
    check({tag, "_flags"}, err_flags, 5'd0);
    check({tag, "_good"}, good_cnt, 32'd0);
    check({tag, "_bad"}, bad_cnt, 32'd0);
    check({tag, "_link"}, link_ok, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; last = 1'b0; user = 1'b0; keep = '0; data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready, 1'b1);

    // 1: basic 64-byte frame
    send_frame(64, 8'h00, -1, 1'b0, 8'h00, 1'b0);
    idle(3);
    // 2: 20 good frames then one corrupted at byte 37
    for (int i = 0; i < 20; i++) send_frame(64, next_seed, -1, 1'b0, 8'h00, i[0]);
    send_frame(64, next_seed, 37, 1'b0, 8'h00, 1'b0);
    idle(2);
    // 3: length boundaries
    send_frame(63, next_seed, -1, 1'b0, 8'h00, 1'b0);
    send_frame(64, next_seed, -1, 1'b0, 8'h00, 1'b0);
    send_frame(9600, next_seed, -1, 1'b0, 8'h00, 1'b0);
    send_frame(9601, next_seed, -1, 1'b0, 8'h00, 1'b0);
    idle(2);
    // 4: user error, then unrelated seed resynchronises
    send_frame(64, next_seed, -1, 1'b1, 8'h00, 1'b0);
    send_frame(80, 8'hC3, -1, 1'b0, 8'h00, 1'b0);
    idle(2);
    // 5: back-to-back seeds 05, 06, 08
    send_frame(64, 8'h05, -1, 1'b0, 8'h00, 1'b0);
    send_frame(64, 8'h06, -1, 1'b0, 8'h00, 1'b0);
    send_frame(64, 8'h08, -1, 1'b0, 8'h00, 1'b0);
    idle(2);
    // non-contiguous keep on last beat, and single-beat frames back-to-back
    send_frame(72, next_seed, -1, 1'b0, 8'h05, 1'b0);
    send_frame(8, next_seed, -1, 1'b0, 8'h00, 1'b0);
    send_frame(3, next_seed, -1, 1'b0, 8'h00, 1'b0);
    idle(2);
    wait_drain();

    // 6: reset in the middle of a 10-beat frame
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      valid = 1'b1; last = 1'b0; keep = 8'hFF;
      for (int l = 0; l < 8; l++) data[8*l +: 8] = 8'(8'h40 + b * 8 + l);
    end
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    m_seq_valid = 1'b0; m_good = 0; m_bad = 0; m_run = 0;
    @(negedge clk);
    send_frame(64, 8'h77, -1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int len;
      logic [7:0] s;
      len = ($urandom_range(9) == 0) ? $urandom_range(1, 63) : $urandom_range(64, 400);
      if ($urandom_range(19) == 0) len = $urandom_range(9590, 9610);
      s   = ($urandom_range(9) == 0) ? 8'($urandom) : next_seed;
      send_frame(len, s, ($urandom_range(9) == 0) ? $urandom_range(1, len) : -1,
                 ($urandom_range(11) == 0), 8'h00, 1'b1);
      if ($urandom_range(1)) idle($urandom_range(1, 3));
    end
    idle(2);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
